div_seq: RTL and testbench

DIV_SEQ -- requirements
Module: div_seq

---
 rtl/div_seq_pkg.sv | 18 +
 rtl/div_seq.sv | 161 ++++++++++++++++
 tb/tb_div_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// div_seq_pkg -- shared definitions for the sequential integer divider.
//
// Contents:
//   DIV_ITERS   default number of quotient bits resolved (one per RUN cycle)
//   DIV_CNT_W   width of the iteration counter
//   divState_t  divider FSM encoding (IDLE / RUN / DONE)
package div_seq_pkg;

    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divState_t;

endpackage

// File: rtl/div_seq.sv
// div_seq -- multi-cycle restoring divider for DIV / DIVU.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   start       divide request (isdivE qualified by EX not stalled/flushed)
//   signed_div  1 = DIV (signed), 0 = DIVU; sampled with start
//   opa, opb    dividend / divisor; sampled with start
//   cancel      abort the divide in flight (flush / exception)
//   stall       hold the front-end pipeline while the divide is outstanding
//   ready       one-cycle pulse in the cycle hi/lo first show a new result
//   hi, lo      remainder / quotient, held until the next result
//   dbgState    current FSM state, for observation only
//
// Handshake: a request is accepted in the cycle start=1, cancel=0 and the
// FSM is IDLE; start at any other time is dropped, never queued. There is
// no back-pressure on the result side: ready is a single-cycle pulse and the
// consumer must capture hi/lo then (they stay stable until the next pulse).
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITERS = DIV_ITERS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    output logic             stall,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output divState_t        dbgState
);

    divState_t state;
    divState_t stateNext;

    logic [DIV_CNT_W-1:0] cnt;
    logic [WIDTH-1:0]     quot;   // dividend shifts out the top, quotient bits in at the bottom
    logic [WIDTH-1:0]     rem;    // partial remainder
    logic [WIDTH:0]       dvsr;   // divisor magnitude
    logic                 negQ;
    logic                 negR;

    logic             accept;
    logic             divByZero;
    logic             lastIter;
    logic [WIDTH:0]   aExt;
    logic [WIDTH:0]   bExt;
    logic [WIDTH:0]   magA;
    logic [WIDTH:0]   magB;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] qNext;
    logic [WIDTH-1:0] rNext;

    assign dbgState  = state;
    assign divByZero = (opb == '0);
    assign accept    = (state == IDLE) && start && !cancel;
    assign lastIter  = (cnt == DIV_CNT_W'(ITERS - 1));

    // Operand magnitudes. Working in WIDTH+1 bits keeps the most negative
    // value's absolute value representable without a special case.
    always_comb begin
        aExt = {signed_div & opa[WIDTH-1], opa};
        bExt = {signed_div & opb[WIDTH-1], opb};
        magA = aExt[WIDTH] ? (~aExt + (WIDTH+1)'(1)) : aExt;
        magB = bExt[WIDTH] ? (~bExt + (WIDTH+1)'(1)) : bExt;
    end

    // One restoring step: shift in the next dividend bit, trial-subtract the
    // divisor, keep the difference only if it did not go negative.
    always_comb begin
        remShift = {rem, quot[WIDTH-1]};
        diff     = remShift - dvsr;
        if (!diff[WIDTH]) begin
            rNext = diff[WIDTH-1:0];
            qNext = {quot[WIDTH-2:0], 1'b1};
        end else begin
            rNext = remShift[WIDTH-1:0];
            qNext = {quot[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and control outputs.
    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !cancel) begin
                    stall     = 1'b1;
                    stateNext = divByZero ? DONE : RUN;
                end
            end
            RUN: begin
                stall = 1'b1;
                if (cancel) begin
                    stateNext = IDLE;
                end else if (lastIter) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                ready     = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Datapath. hi/lo are written only on the edge that enters DONE, so they
    // are valid for the whole DONE cycle and untouched by RUN or a cancel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            quot <= '0;
            rem  <= '0;
            dvsr <= '0;
            negQ <= 1'b0;
            negR <= 1'b0;
            hi   <= '0;
            lo   <= '0;
        end else if (accept) begin
            cnt  <= '0;
            quot <= magA[WIDTH-1:0];
            // The magnitude's top bit is always zero; seeding the partial
            // remainder with it keeps the full WIDTH+1-bit dividend in play.
            rem  <= {{(WIDTH-1){1'b0}}, magA[WIDTH]};
            dvsr <= magB;
            negQ <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            negR <= signed_div & opa[WIDTH-1];
            if (divByZero) begin
                hi <= opa;
                lo <= '1;
            end
        end else if (state == RUN && !cancel) begin
            cnt  <= cnt + DIV_CNT_W'(1);
            quot <= qNext;
            rem  <= rNext;
            if (lastIter) begin
                hi <= negR ? -rNext : rNext;
                lo <= negQ ? -qNext : qNext;
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq -- self-checking bench for div_seq.
//
// Directed steps in one initial block drive divides; each accepted request
// pushes its expected {hi, lo} onto expQ. A negedge monitor pops and checks
// on every ready pulse, so any spurious or missing pulse is reported.
module tb_div_seq;
    import div_seq_pkg::*;

    localparam int W   = 32;
    localparam int LAT = DIV_ITERS + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         signed_div = 1'b0;
    logic [W-1:0] opa = '0;
    logic [W-1:0] opb = '0;
    logic         cancel = 1'b0;
    logic         stall;
    logic         ready;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    divState_t    dbgState;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [2*W-1:0] expQ[$];
    logic [2*W-1:0] monExp;

    div_seq #(.WIDTH(W), .ITERS(DIV_ITERS)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .opa        (opa),
        .opb        (opb),
        .cancel     (cancel),
        .stall      (stall),
        .ready      (ready),
        .hi         (hi),
        .lo         (lo),
        .dbgState   (dbgState)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: SV division truncates toward zero and % takes the
    // dividend's sign; 64-bit arithmetic absorbs the signed overflow case.
    function automatic logic [2*W-1:0] refDiv(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb, q, r;
        if (b == '0) return {a, {W{1'b1}}};
        if (sgn) begin
            sa = {{32{a[W-1]}}, a};
            sb = {{32{b[W-1]}}, b};
            q  = sa / sb;
            r  = sa % sb;
            return {r[W-1:0], q[W-1:0]};
        end
        return {a % b, a / b};
    endfunction

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (ready) begin
            if (expQ.size() == 0) begin
                check("spurious_ready", {63'd0, ready}, 64'd0);
            end else begin
                monExp = expQ.pop_front();
                check("hi", {32'd0, hi}, {32'd0, monExp[2*W-1:W]});
                check("lo", {32'd0, lo}, {32'd0, monExp[W-1:0]});
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one divide in the next cycle and wait (bounded) for ready.
    // poke=1 additionally raises start for a few RUN cycles.
    task automatic runDiv(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] expRes, input int expLat, input bit poke);
        int cyc;
        bit seen;
        nextCycle();
        signed_div = sgn;
        opa        = a;
        opb        = b;
        start      = 1'b1;
        expQ.push_back(expRes);
        #1 check("stall_c0", {63'd0, stall}, 64'd1);
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 100) begin
            nextCycle();
            cyc++;
            start = poke && (cyc >= 4) && (cyc <= 6);
            if (start) begin
                opa = $urandom;
                opb = W'($urandom_range(1, 9));
            end
            #1;
            if (ready) seen = 1;
            else check("stall_run", {63'd0, stall}, 64'd1);
        end
        start = 1'b0;
        check("latency", 64'(cyc), 64'(expLat));
        check("stall_done", {63'd0, stall}, 64'd0);
    endtask

    initial begin
        logic         rs;
        logic [W-1:0] ra, rb;

        // Reset state
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        check("rst_state", {62'd0, dbgState}, {62'd0, IDLE});
        rst = 1'b1;
        nextCycle();
        check("post_rst_state", {62'd0, dbgState}, {62'd0, IDLE});

        // Directed vectors (back-to-back: each starts in the IDLE after DONE)
        runDiv(1'b0, 32'd100,        32'd7,          {32'd2,          32'd14},         LAT, 1'b0);
        runDiv(1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF,   32'hFFFFFFFD},   LAT, 1'b0);
        runDiv(1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h00000000,   32'h80000000},   LAT, 1'b0);
        runDiv(1'b1, 32'd7,          32'hFFFFFFFE,   {32'd1,          32'hFFFFFFFD},   LAT, 1'b0);
        runDiv(1'b0, 32'hFFFFFFFF,   32'h10,         {32'hF,          32'h0FFFFFFF},   LAT, 1'b0);
        runDiv(1'b0, 32'd5,          32'd0,          {32'd5,          32'hFFFFFFFF},   1,   1'b0);
        runDiv(1'b1, 32'hFFFFFFF7,   32'd0,          {32'hFFFFFFF7,   32'hFFFFFFFF},   1,   1'b0);

        // Cancel in RUN at cycle 10
        nextCycle();
        signed_div = 1'b0;
        opa        = 32'd100;
        opb        = 32'd7;
        start      = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            nextCycle();
            start = 1'b0;
        end
        cancel = 1'b1;
        #1 check("cancel_c10_stall", {63'd0, stall}, 64'd1);
        nextCycle();
        cancel = 1'b0;
        #1;
        check("cancel_c11_stall", {63'd0, stall}, 64'd0);
        check("cancel_c11_state", {62'd0, dbgState}, {62'd0, IDLE});
        check("cancel_hold_hi", {32'd0, hi}, 64'hFFFFFFF7);
        check("cancel_hold_lo", {32'd0, lo}, 64'hFFFFFFFF);
        runDiv(1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, LAT, 1'b0);

        // start together with cancel is suppressed
        nextCycle();
        signed_div = 1'b0;
        opa        = 32'd77;
        opb        = 32'd3;
        start      = 1'b1;
        cancel     = 1'b1;
        #1 check("start_cancel_stall", {63'd0, stall}, 64'd0);
        nextCycle();
        start  = 1'b0;
        cancel = 1'b0;
        #1;
        check("start_cancel_state", {62'd0, dbgState}, {62'd0, IDLE});
        check("start_cancel_hi", {32'd0, hi}, 64'd0);
        check("start_cancel_lo", {32'd0, lo}, 64'd100);

        // start during RUN is ignored: exactly one ready
        runDiv(1'b0, 32'd50, 32'd3, {32'd2, 32'd16}, LAT, 1'b1);
        repeat (40) nextCycle();

        // Random operands against the reference model
        for (int i = 0; i < 8; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (i % 3 == 0) ? W'($urandom_range(1, 15)) : $urandom;
            runDiv(rs, ra, rb, refDiv(rs, ra, rb), (rb == '0) ? 1 : LAT, 1'b0);
        end

        // Reset at cycle 15 of RUN
        nextCycle();
        signed_div = 1'b0;
        opa        = 32'd100;
        opb        = 32'd7;
        start      = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            nextCycle();
            start = 1'b0;
        end
        rst = 1'b0;
        #1;
        check("midrst_hi", {32'd0, hi}, 64'd0);
        check("midrst_lo", {32'd0, lo}, 64'd0);
        check("midrst_stall", {63'd0, stall}, 64'd0);
        check("midrst_state", {62'd0, dbgState}, {62'd0, IDLE});
        nextCycle();
        rst = 1'b1;
        repeat (40) nextCycle();
        check("midrst_after_state", {62'd0, dbgState}, {62'd0, IDLE});
        runDiv(1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, LAT, 1'b0);

        nextCycle();
        check("queue_empty", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
